// File: rtl/if_stage.sv
// Instruction fetch stage: PC register, IF/ID pipeline register and
// saturating stall/flush event counters for the pipelined CPU.
module if_stage (
   input  logic        clk,
   input  logic        rst,
   input  logic        cu_wpcir,
   input  logic        cu_branch,
   input  logic [31:0] branch_target,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_data,
   output logic [31:0] if_instr,
   output logic [31:0] instr,
   output logic [31:0] id_pc4,
   output logic        id_valid,
   output logic [15:0] stall_cnt,
   output logic [15:0] flush_cnt
);

   logic [31:0] pc;
   logic [31:0] pc_plus4;

   // Wraps modulo 2^32 naturally through the 32-bit add.
   assign pc_plus4  = pc + 32'd4;
   assign imem_addr = pc;
   assign if_instr  = imem_data;

   // Stall outranks branch: a stalled ID stage has not really resolved its branch yet.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc        <= 32'h0000_0000;
         instr     <= 32'h0000_0000;
         id_pc4    <= 32'h0000_0000;
         id_valid  <= 1'b0;
         stall_cnt <= 16'h0000;
         flush_cnt <= 16'h0000;
      end else if (!cu_wpcir) begin
         if (stall_cnt != 16'hFFFF)
            stall_cnt <= stall_cnt + 16'd1;
      end else if (cu_branch) begin
         pc       <= {branch_target[31:2], 2'b00};
         instr    <= 32'h0000_0000;
         id_pc4   <= 32'h0000_0000;
         id_valid <= 1'b0;
         if (flush_cnt != 16'hFFFF)
            flush_cnt <= flush_cnt + 16'd1;
      end else begin
         pc       <= pc_plus4;
         instr    <= imem_data;
         id_pc4   <= pc_plus4;
         id_valid <= 1'b1;
      end
   end

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: vector table plus hand-written corner
// sequences, with expected results queued on drive and checked after the edge.
module tb_if_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        cu_wpcir;
   logic        cu_branch;
   logic [31:0] branch_target;
   logic [31:0] imem_addr;
   logic [31:0] imem_data;
   logic [31:0] if_instr;
   logic [31:0] instr;
   logic [31:0] id_pc4;
   logic        id_valid;
   logic [15:0] stall_cnt;
   logic [15:0] flush_cnt;

   typedef struct {
      logic        rst;
      logic        wpcir;
      logic        branch;
      logic [31:0] target;
      logic [31:0] exp_pc;
      logic [31:0] exp_instr;
      logic [31:0] exp_pc4;
      logic        exp_valid;
      logic [15:0] exp_sc;
      logic [15:0] exp_fc;
   } vec_t;

   vec_t vecs[20];
   vec_t sb_q[$];
   int   n_compared = 0;
   int   n_mismatch = 0;

   always #5 clk = ~clk;

   if_stage dut (
      .clk(clk), .rst(rst), .cu_wpcir(cu_wpcir), .cu_branch(cu_branch),
      .branch_target(branch_target), .imem_addr(imem_addr), .imem_data(imem_data),
      .if_instr(if_instr), .instr(instr), .id_pc4(id_pc4), .id_valid(id_valid),
      .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   // Instruction memory model; unlisted words carry their own address for easy tracing.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      case (a)
         32'h0000_0000: mem_word = 32'h8c01_0014;
         32'h0000_0004: mem_word = 32'h8c02_0015;
         32'h0000_0008: mem_word = 32'h0022_1820;
         32'h0000_000C: mem_word = 32'h0000_1020;
         32'h0000_0020: mem_word = 32'h10c7_fff8;
         default:       mem_word = {16'hC0DE, a[15:0]};
      endcase
   endfunction

   assign imem_data = mem_word(imem_addr);

   function automatic vec_t mk(input logic r, input logic w, input logic b,
                               input logic [31:0] t, input logic [31:0] pc,
                               input logic [31:0] ins, input logic [31:0] p4,
                               input logic v, input logic [15:0] sc,
                               input logic [15:0] fc);
      vec_t x;
      x.rst = r; x.wpcir = w; x.branch = b; x.target = t;
      x.exp_pc = pc; x.exp_instr = ins; x.exp_pc4 = p4; x.exp_valid = v;
      x.exp_sc = sc; x.exp_fc = fc;
      return x;
   endfunction

   task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_compared++;
      if (act !== exp) begin
         n_mismatch++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Drive at the falling edge so inputs are stable well before the rising edge.
   task automatic applyStimulus(input vec_t v);
      @(negedge clk);
      rst           = v.rst;
      cu_wpcir      = v.wpcir;
      cu_branch     = v.branch;
      branch_target = v.target;
      sb_q.push_back(v);
   endtask

   task automatic checkOutput(input string tag);
      vec_t e;
      @(posedge clk);
      #1;
      if (sb_q.size() == 0) begin
         n_compared++;
         n_mismatch++;
         $display("[TB] FAIL %s scoreboard: got empty queue, expected an entry", tag);
         return;
      end
      e = sb_q.pop_front();
      check_val({tag, " imem_addr"}, imem_addr, e.exp_pc);
      check_val({tag, " if_instr"},  if_instr,  mem_word(e.exp_pc));
      check_val({tag, " instr"},     instr,     e.exp_instr);
      check_val({tag, " id_pc4"},    id_pc4,    e.exp_pc4);
      check_val({tag, " id_valid"},  {31'b0, id_valid},  {31'b0, e.exp_valid});
      check_val({tag, " stall_cnt"}, {16'b0, stall_cnt}, {16'b0, e.exp_sc});
      check_val({tag, " flush_cnt"}, {16'b0, flush_cnt}, {16'b0, e.exp_fc});
   endtask

   initial begin
      #5_000_000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      //          rst  wp   br   target         pc            instr          pc4           v     sc       fc
      vecs[0]  = mk(1, 1, 1, 32'h40,        32'h0,        32'h0,         32'h0,        0, 16'd0, 16'd0);
      vecs[1]  = mk(0, 1, 0, 32'h0,         32'h4,        32'h8c010014,  32'h4,        1, 16'd0, 16'd0);
      vecs[2]  = mk(0, 1, 0, 32'h0,         32'h8,        32'h8c020015,  32'h8,        1, 16'd0, 16'd0);
      vecs[3]  = mk(0, 1, 0, 32'h0,         32'hC,        32'h00221820,  32'hC,        1, 16'd0, 16'd0);
      vecs[4]  = mk(0, 0, 0, 32'h0,         32'hC,        32'h00221820,  32'hC,        1, 16'd1, 16'd0);
      vecs[5]  = mk(0, 1, 0, 32'h0,         32'h10,       32'h00001020,  32'h10,       1, 16'd1, 16'd0);
      vecs[6]  = mk(0, 1, 0, 32'h0,         32'h14,       32'hC0DE0010,  32'h14,       1, 16'd1, 16'd0);
      vecs[7]  = mk(0, 1, 0, 32'h0,         32'h18,       32'hC0DE0014,  32'h18,       1, 16'd1, 16'd0);
      vecs[8]  = mk(0, 1, 0, 32'h0,         32'h1C,       32'hC0DE0018,  32'h1C,       1, 16'd1, 16'd0);
      vecs[9]  = mk(0, 1, 0, 32'h0,         32'h20,       32'hC0DE001C,  32'h20,       1, 16'd1, 16'd0);
      vecs[10] = mk(0, 1, 0, 32'h0,         32'h24,       32'h10c7fff8,  32'h24,       1, 16'd1, 16'd0);
      vecs[11] = mk(0, 1, 1, 32'h4,         32'h4,        32'h0,         32'h0,        0, 16'd1, 16'd1);
      vecs[12] = mk(0, 1, 0, 32'h0,         32'h8,        32'h8c020015,  32'h8,        1, 16'd1, 16'd1);
      vecs[13] = mk(0, 0, 1, 32'h40,        32'h8,        32'h8c020015,  32'h8,        1, 16'd2, 16'd1);
      vecs[14] = mk(0, 1, 1, 32'h7,         32'h4,        32'h0,         32'h0,        0, 16'd2, 16'd2);
      vecs[15] = mk(0, 1, 1, 32'hFFFFFFFE,  32'hFFFFFFFC, 32'h0,         32'h0,        0, 16'd2, 16'd3);
      vecs[16] = mk(0, 1, 0, 32'h0,         32'h0,        32'hC0DEFFFC,  32'h0,        1, 16'd2, 16'd3);
      vecs[17] = mk(0, 0, 0, 32'h0,         32'h0,        32'hC0DEFFFC,  32'h0,        1, 16'd3, 16'd3);
      vecs[18] = mk(1, 0, 1, 32'h80,        32'h0,        32'h0,         32'h0,        0, 16'd0, 16'd0);
      vecs[19] = mk(0, 1, 0, 32'h0,         32'h4,        32'h8c010014,  32'h4,        1, 16'd0, 16'd0);

      rst = 1'b0; cu_wpcir = 1'b0; cu_branch = 1'b0; branch_target = 32'h0;

      for (int i = 0; i < 20; i++) begin
         applyStimulus(vecs[i]);
         checkOutput($sformatf("vec%0d", i));
      end

      // A reset glitch that lands between edges must leave the state alone.
      applyStimulus(mk(0, 0, 0, 32'h0, 32'h4, 32'h8c010014, 32'h4, 1, 16'd1, 16'd0));
      #2 rst = 1'b1;
      #2 rst = 1'b0;
      checkOutput("async_rst_glitch");

      // Long stall: counter must saturate and the held fetch must not be lost.
      @(negedge clk);
      cu_wpcir = 1'b0;
      for (int i = 0; i < 69999; i++) @(negedge clk);
      applyStimulus(mk(0, 0, 0, 32'h0, 32'h4, 32'h8c010014, 32'h4, 1, 16'hFFFF, 16'd0));
      checkOutput("sat_reach");
      applyStimulus(mk(0, 0, 0, 32'h0, 32'h4, 32'h8c010014, 32'h4, 1, 16'hFFFF, 16'd0));
      checkOutput("sat_hold");
      applyStimulus(mk(0, 1, 0, 32'h0, 32'h8, 32'h8c020015, 32'h8, 1, 16'hFFFF, 16'd0));
      checkOutput("after_long_stall");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
      $finish;
   end

endmodule
